// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: command/response framer between a UART byte interface and a
// command processor. Received bytes are assembled MSB-first into a CMD_BYTES
// command word. An inter-byte timeout discards partial frames. A RESP_BYTES
// response word is sent MSB-first as consecutive UART transmissions.
module uart_cmd_framer #(
  parameter int CMD_BYTES  = 2,
  parameter int RESP_BYTES = 1,
  parameter int TO_CYCLES  = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // UART receive side
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  // command side
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    frame_err,
  output logic                    overrun,
  // response side
  input  logic [8*RESP_BYTES-1:0] resp,
  input  logic                    snd_resp,
  output logic                    resp_busy,
  output logic                    resp_done,
  // UART transmit side
  output logic [7:0]              tx_data,
  output logic                    trmt,
  input  logic                    tx_done
);

  localparam int CMD_W  = 8 * CMD_BYTES;
  localparam int RESP_W = 8 * RESP_BYTES;
  localparam int IDX_W  = (CMD_BYTES  > 1) ? $clog2(CMD_BYTES)  : 1;
  localparam int RCNT_W = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;

  typedef enum logic       {RX_IDLE, RX_ASSM}          rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t          rx_state;
  logic [CMD_W-1:0]   rx_shift;
  logic [CMD_W-1:0]   rx_next;
  logic [IDX_W-1:0]   rx_idx;
  logic [31:0]        to_cnt;
  logic               cmd_pend;
  logic               last_byte;
  logic               timeout_hit;

  // The byte is consumed the same cycle it is presented, so the ack is a wire.
  assign clr_rx_rdy  = rx_rdy;
  assign rx_next     = (rx_shift << 8) | CMD_W'(rx_data);
  assign last_byte   = (rx_idx == IDX_W'(CMD_BYTES - 1));
  assign timeout_hit = (TO_CYCLES != 0) && (to_cnt == 32'(TO_CYCLES - 1));

  // Command assembly, timeout and cmd_rdy/overrun handling.
  // cmd_pend remembers an unacknowledged command even after the first byte of
  // the next frame drops cmd_rdy, so an overwrite is still reported as overrun.
  // NOTE: all state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_shift  <= '0;
      rx_idx    <= '0;
      to_cnt    <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      cmd_pend  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer ack first; a completion below in the same cycle overrides it.
      if (clr_cmd_rdy) begin
        cmd_rdy  <= 1'b0;
        cmd_pend <= 1'b0;
      end
      if (rx_rdy) begin
        to_cnt <= '0;
        if (last_byte) begin
          cmd      <= rx_next;
          cmd_rdy  <= 1'b1;
          cmd_pend <= 1'b1;
          overrun  <= cmd_pend;
          rx_shift <= '0;
          rx_idx   <= '0;
          rx_state <= RX_IDLE;
        end else begin
          rx_shift <= rx_next;
          rx_idx   <= rx_idx + IDX_W'(1);
          rx_state <= RX_ASSM;
          if (rx_idx == '0) cmd_rdy <= 1'b0;
        end
      end else if (rx_state == RX_ASSM) begin
        if (timeout_hit) begin
          rx_shift  <= '0;
          rx_idx    <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          rx_state  <= RX_IDLE;
        end else if (TO_CYCLES != 0) begin
          to_cnt <= to_cnt + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t           tx_state;
  logic [RESP_W-1:0]   tx_shift;
  logic [RCNT_W-1:0]   tx_left;

  // Response serialiser: latch, strobe each byte, wait for tx_done, repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '0;
      tx_left   <= '0;
      resp_busy <= 1'b0;
      resp_done <= 1'b0;
      tx_data   <= '0;
      trmt      <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (snd_resp) begin
            tx_shift  <= resp;
            tx_left   <= RCNT_W'(RESP_BYTES - 1);
            resp_busy <= 1'b1;
            tx_state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          trmt     <= 1'b1;
          tx_data  <= tx_shift[RESP_W-1 -: 8];
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            tx_shift <= tx_shift << 8;
            if (tx_left != '0) begin
              tx_left  <= tx_left - RCNT_W'(1);
              tx_state <= TX_SEND;
            end else begin
              resp_done <= 1'b1;
              resp_busy <= 1'b0;
              tx_state  <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed, table-driven bench for uart_cmd_framer.
// u2: 2-byte command, 2-byte response, 50-cycle timeout.
// u3: 3-byte command, 1-byte response, timeout disabled.
module tb_uart_cmd_framer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u2 signals
  logic        rx_rdy2, clr_rx_rdy2, cmd_rdy2, clr_cmd_rdy2, frame_err2, overrun2;
  logic [7:0]  rx_data2, tx_data2;
  logic [15:0] cmd2, resp2;
  logic        snd_resp2, resp_busy2, resp_done2, trmt2, tx_done2;
  // u3 signals
  logic        rx_rdy3, clr_rx_rdy3, cmd_rdy3, clr_cmd_rdy3, frame_err3, overrun3;
  logic [7:0]  rx_data3, tx_data3, resp3;
  logic [23:0] cmd3;
  logic        snd_resp3, resp_busy3, resp_done3, trmt3, tx_done3;

  uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(2), .TO_CYCLES(50)) u2 (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy2), .rx_data(rx_data2), .clr_rx_rdy(clr_rx_rdy2),
    .cmd(cmd2), .cmd_rdy(cmd_rdy2), .clr_cmd_rdy(clr_cmd_rdy2),
    .frame_err(frame_err2), .overrun(overrun2),
    .resp(resp2), .snd_resp(snd_resp2), .resp_busy(resp_busy2), .resp_done(resp_done2),
    .tx_data(tx_data2), .trmt(trmt2), .tx_done(tx_done2)
  );

  uart_cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(1), .TO_CYCLES(0)) u3 (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy3), .rx_data(rx_data3), .clr_rx_rdy(clr_rx_rdy3),
    .cmd(cmd3), .cmd_rdy(cmd_rdy3), .clr_cmd_rdy(clr_cmd_rdy3),
    .frame_err(frame_err3), .overrun(overrun3),
    .resp(resp3), .snd_resp(snd_resp3), .resp_busy(resp_busy3), .resp_done(resp_done3),
    .tx_data(tx_data3), .trmt(trmt3), .tx_done(tx_done3)
  );

  int checks = 0;
  int errors = 0;
  int vnum   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One RX cycle: inputs for the selected instance plus expected registered outputs.
  typedef struct {
    logic        dut3;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr;
    logic        exp_rdy;
    logic [23:0] exp_cmd;
    logic        exp_fe;
    logic        exp_ov;
  } rx_vec_t;

  rx_vec_t vecs[$];

  function automatic rx_vec_t mk(input logic d3, input logic rr, input logic [7:0] rd,
                                 input logic cl, input logic er, input logic [23:0] ec,
                                 input logic ef, input logic eo);
    rx_vec_t v;
    v.dut3 = d3; v.rx_rdy = rr; v.rx_data = rd; v.clr = cl;
    v.exp_rdy = er; v.exp_cmd = ec; v.exp_fe = ef; v.exp_ov = eo;
    return v;
  endfunction

  task automatic drive_idle();
    rx_rdy2 = 1'b0; rx_data2 = 8'h00; clr_cmd_rdy2 = 1'b0;
    rx_rdy3 = 1'b0; rx_data3 = 8'h00; clr_cmd_rdy3 = 1'b0;
  endtask

  task automatic apply(input rx_vec_t v);
    @(negedge clk);
    drive_idle();
    if (v.dut3) begin
      rx_rdy3 = v.rx_rdy; rx_data3 = v.rx_data; clr_cmd_rdy3 = v.clr;
    end else begin
      rx_rdy2 = v.rx_rdy; rx_data2 = v.rx_data; clr_cmd_rdy2 = v.clr;
    end
    #1;
    check($sformatf("v%0d clr_rx_rdy", vnum), v.dut3 ? clr_rx_rdy3 : clr_rx_rdy2, v.rx_rdy);
    @(posedge clk);
    #1;
    check($sformatf("v%0d cmd_rdy", vnum),   v.dut3 ? cmd_rdy3 : cmd_rdy2,     v.exp_rdy);
    check($sformatf("v%0d cmd", vnum),       v.dut3 ? cmd3 : 24'(cmd2),        v.exp_cmd);
    check($sformatf("v%0d frame_err", vnum), v.dut3 ? frame_err3 : frame_err2, v.exp_fe);
    check($sformatf("v%0d overrun", vnum),   v.dut3 ? overrun3 : overrun2,     v.exp_ov);
    vnum++;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  // n idle cycles on the RX side; reports frame_err pulses and the first cycle one was seen.
  task automatic idle_cycles(input int n, input bit dut3, output int fe_cnt, output int first_fe);
    fe_cnt = 0; first_fe = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      if (dut3 ? frame_err3 : frame_err2) begin
        fe_cnt++;
        if (first_fe == 0) first_fe = i;
      end
    end
  endtask

  // Transmit monitors
  logic [7:0] log2[$];
  logic [7:0] log3[$];
  int done2 = 0;
  int done3 = 0;
  always @(negedge clk) begin
    if (trmt2) log2.push_back(tx_data2);
    if (trmt3) log3.push_back(tx_data3);
    if (resp_done2) done2++;
    if (resp_done3) done3++;
  end

  task automatic check_reset_u2(input string tag);
    check({tag, " cmd"},       cmd2,       0);
    check({tag, " cmd_rdy"},   cmd_rdy2,   0);
    check({tag, " frame_err"}, frame_err2, 0);
    check({tag, " overrun"},   overrun2,   0);
    check({tag, " resp_busy"}, resp_busy2, 0);
    check({tag, " resp_done"}, resp_done2, 0);
    check({tag, " tx_data"},   tx_data2,   0);
    check({tag, " trmt"},      trmt2,      0);
  endtask

  int fe_cnt, first_fe;

  initial begin
    rst_n = 1'b0;
    drive_idle();
    resp2 = '0; snd_resp2 = 1'b0; tx_done2 = 1'b0;
    resp3 = '0; snd_resp3 = 1'b0; tx_done3 = 1'b0;
    #12;
    check_reset_u2("rst0");
    check("rst0 u3 cmd", cmd3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic assembly, level hold, ack, set-wins-over-clear, first-byte clear.
    vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 24'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h3C, 0, 1, 24'hA53C, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 24'hA53C, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 24'hA53C, 0, 0));
    vecs.push_back(mk(0, 1, 8'hDE, 0, 0, 24'hA53C, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAD, 1, 1, 24'hDEAD, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 24'hDEAD, 0, 0));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 24'hDEAD, 0, 0));
    run_vecs();

    // Timeout: 50 idle cycles after one byte gives exactly one frame_err, on cycle 50.
    idle_cycles(55, 1'b0, fe_cnt, first_fe);
    check("timeout pulses", fe_cnt, 1);
    check("timeout cycle", first_fe, 50);
    check("timeout cmd_rdy", cmd_rdy2, 0);

    vecs.push_back(mk(0, 1, 8'h34, 0, 0, 24'hDEAD, 0, 0));
    vecs.push_back(mk(0, 1, 8'h56, 0, 1, 24'h3456, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 24'h3456, 0, 0));
    vecs.push_back(mk(0, 1, 8'h9A, 0, 0, 24'h3456, 0, 0));
    run_vecs();

    // One cycle short of the timeout: the frame survives.
    idle_cycles(49, 1'b0, fe_cnt, first_fe);
    check("no-timeout pulses", fe_cnt, 0);

    vecs.push_back(mk(0, 1, 8'hBC, 0, 1, 24'h9ABC, 0, 0));
    // 3-byte commands with overwrite of an unacknowledged command.
    vecs.push_back(mk(1, 1, 8'h01, 0, 0, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 1, 8'h02, 0, 0, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 1, 8'h03, 0, 1, 24'h010203, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 24'h010203, 0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 0, 0, 24'h010203, 0, 0));
    vecs.push_back(mk(1, 1, 8'h05, 0, 0, 24'h010203, 0, 0));
    vecs.push_back(mk(1, 1, 8'h06, 0, 1, 24'h040506, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 24'h040506, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 24'h040506, 0, 0));
    vecs.push_back(mk(1, 1, 8'h07, 0, 0, 24'h040506, 0, 0));
    run_vecs();

    // Timeout disabled: a long gap does not abort the frame.
    idle_cycles(200, 1'b1, fe_cnt, first_fe);
    check("u3 no timeout", fe_cnt, 0);
    vecs.push_back(mk(1, 1, 8'h08, 0, 0, 24'h040506, 0, 0));
    vecs.push_back(mk(1, 1, 8'h09, 0, 1, 24'h070809, 0, 0));
    run_vecs();

    // Two-byte response with a snd_resp attempt while busy.
    @(negedge clk);
    drive_idle();
    resp2 = 16'hBEEF; snd_resp2 = 1'b1;
    @(posedge clk); #1;
    check("tx n+1 trmt", trmt2, 0);
    check("tx n+1 busy", resp_busy2, 1);
    @(negedge clk);
    snd_resp2 = 1'b0; resp2 = 16'h0000;
    @(posedge clk); #1;
    check("tx n+2 trmt", trmt2, 1);
    check("tx byte0", tx_data2, 8'hBE);
    @(negedge clk);
    resp2 = 16'h1234; snd_resp2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("tx trmt one cycle", trmt2, 0);
    @(negedge clk);
    tx_done2 = 1'b1;
    @(posedge clk); #1;
    check("tx after done0 trmt", trmt2, 0);
    @(negedge clk);
    tx_done2 = 1'b0;
    @(posedge clk); #1;
    check("tx byte1 trmt", trmt2, 1);
    check("tx byte1", tx_data2, 8'hEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    snd_resp2 = 1'b0;
    tx_done2  = 1'b1;
    @(posedge clk); #1;
    check("tx resp_done", resp_done2, 1);
    check("tx busy cleared", resp_busy2, 0);
    @(negedge clk);
    tx_done2 = 1'b0;
    @(posedge clk); #1;
    check("tx resp_done pulse", resp_done2, 0);
    check("tx_data held", tx_data2, 8'hEF);
    // tx_done while idle must not produce anything.
    @(negedge clk);
    tx_done2 = 1'b1;
    @(negedge clk);
    tx_done2 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("tx byte count", log2.size(), 2);
    if (log2.size() == 2) begin
      check("tx log0", log2[0], 8'hBE);
      check("tx log1", log2[1], 8'hEF);
    end
    check("tx resp_done count", done2, 1);

    // Single-byte response on u3.
    @(negedge clk);
    resp3 = 8'h5A; snd_resp3 = 1'b1;
    @(negedge clk);
    snd_resp3 = 1'b0;
    repeat (3) @(negedge clk);
    tx_done3 = 1'b1;
    @(posedge clk); #1;
    check("u3 resp_done", resp_done3, 1);
    check("u3 busy", resp_busy3, 0);
    @(negedge clk);
    tx_done3 = 1'b0;
    check("u3 byte count", log3.size(), 1);
    if (log3.size() == 1) check("u3 log0", log3[0], 8'h5A);

    // Reset in the middle of a frame discards the partial command.
    vecs.push_back(mk(0, 1, 8'h55, 0, 0, 24'h9ABC, 0, 0));
    run_vecs();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_reset_u2("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    vecs.push_back(mk(0, 1, 8'h77, 0, 0, 24'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 8'h88, 0, 1, 24'h7788, 0, 0));
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
